// File: rtl/fb_read_arbiter.sv
// Frame-buffer port-B read arbiter: VGA (A) has strict priority over the
// OLED scanner (B). The winning address is registered into the BRAM and the
// returned pixel is steered to its owner two cycles after the request.
module fb_read_arbiter #(
  parameter int c_nb_img_pxls = 15,
  parameter int c_nb_buf      = 12,
  parameter int c_starve_max  = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     a_req_i,
  input  logic [c_nb_img_pxls-1:0] a_addr_i,
  output logic                     a_rvalid_o,
  output logic [c_nb_buf-1:0]      a_rdata_o,
  input  logic                     b_req_i,
  input  logic [c_nb_img_pxls-1:0] b_addr_i,
  output logic                     b_gnt_o,
  output logic                     b_rvalid_o,
  output logic [c_nb_buf-1:0]      b_rdata_o,
  output logic [c_nb_img_pxls-1:0] fb_addr_o,
  input  logic [c_nb_buf-1:0]      fb_dout_i,
  input  logic                     starve_clr_i,
  output logic                     b_starve_o
);

  localparam logic [7:0] STARVE_MAX = 8'(c_starve_max);

  // Return-path tag: which requester owns the read in flight.
  typedef struct packed {
    logic vld;
    logic own_b;
  } sel_t;

  sel_t                     sel1_q, sel1_d, sel2_q;
  logic [c_nb_img_pxls-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]               wait_q, wait_d;
  logic                     starve_q, starve_d;
  logic                     b_gnt, b_wait, starve_set;

  // Arbitration, address/tag capture and starvation bookkeeping.
  always_comb begin
    b_gnt      = b_req_i & ~a_req_i & ~rst_i;
    b_wait     = b_req_i & ~b_gnt;
    fb_addr_d  = fb_addr_q;  // hold address when idle: no spurious BRAM reads
    sel1_d     = '0;
    if (a_req_i) begin
      fb_addr_d = a_addr_i;
      sel1_d    = '{vld: 1'b1, own_b: 1'b0};
    end else if (b_gnt) begin
      fb_addr_d = b_addr_i;
      sel1_d    = '{vld: 1'b1, own_b: 1'b1};
    end
    wait_d = 8'd0;
    if (b_wait)
      wait_d = (wait_q == STARVE_MAX) ? wait_q : wait_q + 8'd1;
    starve_set = b_wait & (wait_q == STARVE_MAX - 8'd1);
    // a set in the same cycle as a clear must win so no event is lost
    starve_d = starve_q;
    if (starve_set)        starve_d = 1'b1;
    else if (starve_clr_i) starve_d = 1'b0;
  end

  // State registers; reset drops any in-flight reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fb_addr_q <= '0;
      sel1_q    <= '0;
      sel2_q    <= '0;
      wait_q    <= 8'd0;
      starve_q  <= 1'b0;
    end else begin
      fb_addr_q <= fb_addr_d;
      sel1_q    <= sel1_d;
      sel2_q    <= sel1_q;  // aligns tag with BRAM output one cycle later
      wait_q    <= wait_d;
      starve_q  <= starve_d;
    end
  end

  assign b_gnt_o    = b_gnt;
  assign fb_addr_o  = fb_addr_q;
  assign a_rvalid_o = sel2_q.vld & ~sel2_q.own_b;
  assign b_rvalid_o = sel2_q.vld &  sel2_q.own_b;
  assign a_rdata_o  = fb_dout_i;
  assign b_rdata_o  = fb_dout_i;
  assign b_starve_o = starve_q;

endmodule
